// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: geometry constants and the arbiter state type.
package fb_pkg;

   localparam int FB_ADDR_W     = 15;
   localparam int FB_DATA_W     = 4;
   localparam int FB_LINE_WORDS = 80;   // word address = col + line * FB_LINE_WORDS

   // Last grant type issued by the arbiter
   typedef enum logic {
      S_RD = 1'b0,
      S_WR = 1'b1
   } fb_arb_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous write buffer holding {address, nibble} pairs.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise the entry is discarded and o_drop pulses.
module fb_wr_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = FB_ADDR_W,
   parameter int DW    = FB_DATA_W
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [AW-1:0]            i_addr,
   input  logic [DW-1:0]            i_data,
   input  logic                     i_pop,
   output logic [AW-1:0]            o_addr,
   output logic [DW-1:0]            o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic                     o_drop,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [AW+DW-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_level == LVL_W'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_drop    = i_push & o_full & ~w_do_pop;
   assign o_level   = r_level;

   // Head entry is presented combinationally so the arbiter can drive the RAM this cycle
   assign {o_addr, o_data} = r_mem[r_rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Entry storage, no reset needed: contents are only consumed when valid
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= {i_addr, i_data};
   end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port RAM between buffered pixel
// writes and scanout reads. Reads win unless the write buffer is full or a
// read burst has run MAX_RD_BURST grants with writes waiting.
// Optional statistics counters (dropCnt, stallCnt) are built when the macro
// FB_ARB_STATS_EN is defined.
module fb_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W       = FB_ADDR_W,
   parameter int DATA_W       = FB_DATA_W,
   parameter int WFIFO_DEPTH  = 4,
   parameter int MAX_RD_BURST = 8
) (
   input  logic                         pixClk,
   input  logic                         nRst,
   input  logic                         wrPix,
   input  logic [ADDR_W-1:0]            wrAddr,
   input  logic [DATA_W-1:0]            wrData,
   input  logic                         rdReq,
   input  logic [ADDR_W-1:0]            rdAddr,
   output logic                         rdGnt,
   output logic                         rdValid,
   output logic [DATA_W-1:0]            rdData,
   output logic [ADDR_W-1:0]            memAddr,
   output logic                         memWe,
   output logic [DATA_W-1:0]            memWdata,
   input  logic [DATA_W-1:0]            memRdata,
   input  logic                         ovflClr,
   output logic                         ovfl,
   output logic [$clog2(WFIFO_DEPTH):0] fifoLevel
`ifdef FB_ARB_STATS_EN
   ,
   output logic [15:0]                  dropCnt,
   output logic [15:0]                  stallCnt
`endif
);

   localparam int BC_W = $clog2(MAX_RD_BURST + 1);

   logic                r_wrPix_q;
   logic                w_push;
   logic                w_full;
   logic                w_empty;
   logic                w_drop;
   logic [ADDR_W-1:0]   w_head_addr;
   logic [DATA_W-1:0]   w_head_data;
   logic                w_force;
   logic                w_rd_gnt;
   logic                w_wr_gnt;
   logic [BC_W-1:0]     r_burstCnt;
   logic [BC_W-1:0]     w_burstCnt_next;
   fb_arb_state_t       r_state;
   fb_arb_state_t       w_state_next;
   logic [ADDR_W-1:0]   r_last_addr;
   logic [DATA_W-1:0]   r_last_wdata;
   logic                r_rdValid;
   logic [DATA_W-1:0]   r_rdData;
   logic                r_ovfl;

   // One push per rising edge of the write strobe
   assign w_push = wrPix & ~r_wrPix_q;

   fb_wr_fifo #(
      .DEPTH (WFIFO_DEPTH),
      .AW    (ADDR_W),
      .DW    (DATA_W)
   ) u_wr_fifo (
      .i_clk   (pixClk),
      .i_rst_n (nRst),
      .i_push  (w_push),
      .i_addr  (wrAddr),
      .i_data  (wrData),
      .i_pop   (w_wr_gnt),
      .o_addr  (w_head_addr),
      .o_data  (w_head_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_drop  (w_drop),
      .o_level (fifoLevel)
   );

   assign w_force = w_full | ((r_burstCnt == BC_W'(MAX_RD_BURST)) & ~w_empty);

   // State register: remembers the last grant type
   always_ff @(posedge pixClk or negedge nRst) begin
      if (!nRst) r_state <= S_RD;
      else       r_state <= w_state_next;
   end

   // Next-state: follow whichever grant was issued, hold while idle
   always_comb begin
      w_state_next = r_state;
      if (w_wr_gnt)      w_state_next = S_WR;
      else if (w_rd_gnt) w_state_next = S_RD;
   end

   // Grant decision and RAM port drive; grants are suppressed while in reset
   always_comb begin
      w_rd_gnt = 1'b0;
      w_wr_gnt = 1'b0;
      if (nRst) begin
         if (w_force)       w_wr_gnt = 1'b1;
         else if (rdReq)    w_rd_gnt = 1'b1;
         else if (!w_empty) w_wr_gnt = 1'b1;
      end
      rdGnt    = w_rd_gnt;
      memWe    = w_wr_gnt;
      memAddr  = r_last_addr;
      memWdata = r_last_wdata;
      if (w_wr_gnt) begin
         memAddr  = w_head_addr;
         memWdata = w_head_data;
      end else if (w_rd_gnt) begin
         memAddr  = rdAddr;
      end
   end

   // Burst length: counts reads granted while writes are waiting
   always_comb begin
      w_burstCnt_next = r_burstCnt;
      if (w_wr_gnt || w_empty)
         w_burstCnt_next = '0;
      else if (w_rd_gnt && (r_burstCnt != BC_W'(MAX_RD_BURST)))
         w_burstCnt_next = r_burstCnt + BC_W'(1);
   end

   // Edge detector, burst counter, held RAM drive values and read pipeline
   always_ff @(posedge pixClk or negedge nRst) begin
      if (!nRst) begin
         r_wrPix_q    <= 1'b0;
         r_burstCnt   <= '0;
         r_last_addr  <= '0;
         r_last_wdata <= '0;
         r_rdValid    <= 1'b0;
         r_rdData     <= '0;
      end else begin
         r_wrPix_q    <= wrPix;
         r_burstCnt   <= w_burstCnt_next;
         r_last_addr  <= memAddr;
         r_last_wdata <= memWdata;
         r_rdValid    <= w_rd_gnt;
         if (r_rdValid) r_rdData <= memRdata;
      end
   end

   // Read data follows the RAM on the valid cycle and holds afterwards
   assign rdValid = r_rdValid;
   assign rdData  = r_rdValid ? memRdata : r_rdData;

   // Sticky overflow flag; a new drop beats a simultaneous clear
   always_ff @(posedge pixClk or negedge nRst) begin
      if (!nRst)        r_ovfl <= 1'b0;
      else if (w_drop)  r_ovfl <= 1'b1;
      else if (ovflClr) r_ovfl <= 1'b0;
   end

   assign ovfl = r_ovfl;

`ifdef FB_ARB_STATS_EN
   logic [15:0] r_dropCnt;
   logic [15:0] r_stallCnt;

   // Saturating counters of dropped writes and stalled read cycles
   always_ff @(posedge pixClk or negedge nRst) begin
      if (!nRst) begin
         r_dropCnt  <= '0;
         r_stallCnt <= '0;
      end else begin
         if (w_drop && (r_dropCnt != 16'hFFFF))
            r_dropCnt <= r_dropCnt + 16'd1;
         if (rdReq && !w_rd_gnt && (r_stallCnt != 16'hFFFF))
            r_stallCnt <= r_stallCnt + 16'd1;
      end
   end

   assign dropCnt  = r_dropCnt;
   assign stallCnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: reference model predicts grants, RAM traffic and read
// data into queues; a negedge monitor pops and compares against the DUT.
module tb_fb_arbiter;

   localparam int AW    = 15;
   localparam int DW    = 4;
   localparam int DEPTH = 4;
   localparam int MAXB  = 8;
   localparam int LW    = 3;

   typedef struct {
      int            stamp;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          pixClk;
   logic          nRst;
   logic          wrPix;
   logic [AW-1:0] wrAddr;
   logic [DW-1:0] wrData;
   logic          rdReq;
   logic [AW-1:0] rdAddr;
   logic          rdGnt;
   logic          rdValid;
   logic [DW-1:0] rdData;
   logic [AW-1:0] memAddr;
   logic          memWe;
   logic [DW-1:0] memWdata;
   logic [DW-1:0] memRdata;
   logic          ovflClr;
   logic          ovfl;
   logic [LW-1:0] fifoLevel;
`ifdef FB_ARB_STATS_EN
   logic [15:0]   dropCnt;
   logic [15:0]   stallCnt;
`endif

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // scoreboard queues filled by the model
   ent_t exp_wr[$];
   ent_t exp_gnt[$];
   ent_t exp_rd[$];
   int   exp_level = 0;
   logic exp_ovfl  = 1'b0;
   int   exp_drop  = 0;
   int   exp_stall = 0;

   // monitor statistics
   logic gnt_seen    = 1'b0;
   int   we_cnt      = 0;
   int   last_we_cyc = 0;
   int   max_lvl     = 0;
   int   run         = 0;
   int   max_run     = 0;

   fb_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(DEPTH), .MAX_RD_BURST(MAXB)
   ) dut (
      .pixClk(pixClk), .nRst(nRst), .wrPix(wrPix), .wrAddr(wrAddr), .wrData(wrData),
      .rdReq(rdReq), .rdAddr(rdAddr), .rdGnt(rdGnt), .rdValid(rdValid), .rdData(rdData),
      .memAddr(memAddr), .memWe(memWe), .memWdata(memWdata), .memRdata(memRdata),
      .ovflClr(ovflClr), .ovfl(ovfl), .fifoLevel(fifoLevel)
`ifdef FB_ARB_STATS_EN
      , .dropCnt(dropCnt), .stallCnt(stallCnt)
`endif
   );

   initial begin
      pixClk = 1'b0;
      forever #5 pixClk = ~pixClk;
   end

   always @(posedge pixClk) cyc++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail_evt(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic logic [DW-1:0] init_word(input int a);
      return DW'(a) ^ DW'(a >> 4);
   endfunction

   // RAM model: synchronous read, one-cycle latency, read-before-write
   logic [DW-1:0] ram [0:(1<<AW)-1];
   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = init_word(i);
      memRdata = '0;
      forever begin
         @(posedge pixClk);
         memRdata <= ram[memAddr];
         if (memWe) ram[memAddr] = memWdata;
      end
   end

   // Reference model: applies the arbitration rules once per cycle
   initial begin : model
      logic [DW-1:0] shadow [0:(1<<AW)-1];
      wr_t  mq[$];
      wr_t  e;
      int   burst;
      logic m_ovfl;
      logic prev;
      int   m_drop;
      int   m_stall;
      logic push, full, nonempty, force_wr, popped, rdg, dropped;
      for (int i = 0; i < (1 << AW); i++) shadow[i] = init_word(i);
      burst = 0; m_ovfl = 0; prev = 0; m_drop = 0; m_stall = 0;
      forever begin
         @(posedge pixClk);
         #4;
         if (!nRst) begin
            mq.delete(); exp_wr.delete(); exp_gnt.delete(); exp_rd.delete();
            burst = 0; m_ovfl = 0; prev = 0; m_drop = 0; m_stall = 0;
            exp_level = 0; exp_ovfl = 0; exp_drop = 0; exp_stall = 0;
         end else begin
            exp_level = mq.size();
            exp_ovfl  = m_ovfl;
            exp_drop  = m_drop;
            exp_stall = m_stall;
            push      = wrPix && !prev;
            nonempty  = (mq.size() != 0);
            full      = (mq.size() == DEPTH);
            force_wr  = full || (burst == MAXB && nonempty);
            popped    = 0;
            rdg       = 0;
            if (force_wr || (!rdReq && nonempty)) begin
               e = mq.pop_front();
               exp_wr.push_back('{cyc, e.addr, e.data});
               shadow[e.addr] = e.data;
               burst  = 0;
               popped = 1;
            end else if (rdReq) begin
               rdg = 1;
               exp_gnt.push_back('{cyc, rdAddr, '0});
               exp_rd.push_back('{cyc + 1, rdAddr, shadow[rdAddr]});
               if (!nonempty)         burst = 0;
               else if (burst < MAXB) burst++;
            end else begin
               burst = 0;
            end
            if (rdReq && !rdg && m_stall < 65535) m_stall++;
            dropped = 0;
            if (push) begin
               if (full && !popped) begin
                  dropped = 1;
                  m_ovfl  = 1;
                  if (m_drop < 65535) m_drop++;
               end else begin
                  mq.push_back('{wrAddr, wrData});
               end
            end
            if (!dropped && ovflClr) m_ovfl = 0;
            prev = wrPix;
         end
      end
   end

   // Monitor: compares DUT activity against the model's expectations
   always @(negedge pixClk) begin
      ent_t e;
      gnt_seen = rdGnt;
      if (nRst) begin
         if (memWe) begin
            we_cnt++;
            last_we_cyc = cyc;
            if (exp_wr.size() == 0) fail_evt("wr_unexpected");
            else begin
               e = exp_wr.pop_front();
               check("wr_cycle", cyc, e.stamp);
               check("wr_addr", memAddr, e.addr);
               check("wr_data", memWdata, e.data);
            end
         end else if (exp_wr.size() != 0 && exp_wr[0].stamp <= cyc) begin
            fail_evt("wr_missing");
            void'(exp_wr.pop_front());
         end
         if (rdGnt) begin
            if (exp_gnt.size() == 0) fail_evt("gnt_unexpected");
            else begin
               e = exp_gnt.pop_front();
               check("gnt_cycle", cyc, e.stamp);
               check("rd_addr", memAddr, e.addr);
            end
         end else if (exp_gnt.size() != 0 && exp_gnt[0].stamp <= cyc) begin
            fail_evt("gnt_missing");
            void'(exp_gnt.pop_front());
         end
         if (rdValid) begin
            if (exp_rd.size() == 0) fail_evt("rdvalid_unexpected");
            else begin
               e = exp_rd.pop_front();
               check("rdvalid_cycle", cyc, e.stamp);
               check("rd_data", rdData, e.data);
            end
         end else if (exp_rd.size() != 0 && exp_rd[0].stamp <= cyc) begin
            fail_evt("rdvalid_missing");
            void'(exp_rd.pop_front());
         end
         check("fifo_level", fifoLevel, exp_level);
         check("ovfl", ovfl, exp_ovfl);
`ifdef FB_ARB_STATS_EN
         check("drop_cnt", dropCnt, exp_drop);
         check("stall_cnt", stallCnt, exp_stall);
`endif
         if (int'(fifoLevel) > max_lvl) max_lvl = fifoLevel;
         if (fifoLevel != 0 && !memWe) run++;
         else run = 0;
         if (run > max_run) max_run = run;
      end
   end

   task automatic step();
      @(posedge pixClk);
      #2;
   endtask

   // advance one cycle; present a new read address once the last one was granted
   task automatic rd_step();
      step();
      if (gnt_seen) rdAddr = AW'($urandom);
   endtask

   initial begin : stim
      int s;
      int we0;
      int tmo;
      nRst = 0; wrPix = 0; wrAddr = '0; wrData = '0;
      rdReq = 0; rdAddr = '0; ovflClr = 0;
      repeat (3) step();
      @(negedge pixClk);
      check("rst_rdGnt", rdGnt, 0);
      check("rst_memWe", memWe, 0);
      check("rst_rdValid", rdValid, 0);
      check("rst_fifoLevel", fifoLevel, 0);
      check("rst_ovfl", ovfl, 0);
      check("rst_memAddr", memAddr, 0);
      check("rst_memWdata", memWdata, 0);
      check("rst_rdData", rdData, 0);
      step();
      nRst = 1;
      repeat (2) step();

      // single write, strobe held high for five cycles
      wrAddr = 15'h0051; wrData = 4'hA; wrPix = 1;
      s = cyc; we0 = we_cnt;
      repeat (5) step();
      wrPix = 0;
      repeat (4) step();
      check("single_we_count", we_cnt - we0, 1);
      check("single_we_cycle", last_we_cyc, s + 1);

      // read latency
      rdAddr = 15'h0050; rdReq = 1;
      @(negedge pixClk);
      check("rdlat_gnt", rdGnt, 1);
      step();
      rdReq = 0;
      @(negedge pixClk);
      check("rdlat_valid", rdValid, 1);
      check("rdlat_data", rdData, 4'h5);
      step();
      @(negedge pixClk);
      check("rdlat_valid_drop", rdValid, 0);
      check("rdlat_data_hold", rdData, 4'h5);
      step();

      // starvation: continuous reads with one write
      rdReq = 1; rdAddr = AW'($urandom);
      rd_step();
      wrAddr = AW'($urandom); wrData = DW'($urandom); wrPix = 1;
      s = cyc; we0 = we_cnt;
      rd_step();
      wrPix = 0;
      repeat (14) rd_step();
      check("starve_we_count", we_cnt - we0, 1);
      check("starve_latency_ok", ((last_we_cyc - s) >= 1) && ((last_we_cyc - s) <= MAXB + 1), 1);

      // six pushes two cycles apart under continuous reads
      max_lvl = 0;
      for (int i = 0; i < 6; i++) begin
         wrAddr = AW'($urandom); wrData = DW'($urandom); wrPix = 1;
         rd_step();
         wrPix = 0;
         rd_step();
      end
      repeat (16) rd_step();
      check("ovf_spaced_maxlvl", max_lvl, DEPTH);
      check("ovf_spaced_ovfl", ovfl, 0);

      // strobe toggled every cycle, then clear the flag
      for (int i = 0; i < 12; i++) begin
         wrAddr = AW'($urandom); wrData = DW'($urandom); wrPix = ~wrPix;
         rd_step();
      end
      wrPix = 0;
      ovflClr = 1;
      rd_step();
      ovflClr = 0;
      repeat (12) rd_step();
      @(negedge pixClk);
      check("ovfl_after_clr", ovfl, 0);
`ifdef FB_ARB_STATS_EN
      check("dropcnt_after_ovf", dropCnt, 0);
`endif

      // reset asserted on a read-grant cycle with writes pending
      step();
      tmo = 0;
      while (1) begin
         wrAddr = AW'($urandom); wrData = DW'($urandom); wrPix = ~wrPix;
         @(negedge pixClk);
         if (rdGnt && fifoLevel != 0) break;
         tmo++;
         if (tmo > 40) begin
            fail_evt("rst_gnt_timeout");
            break;
         end
         rd_step();
      end
      #1 nRst = 0;
      rdReq = 0; wrPix = 0;
      @(negedge pixClk);
      check("rstmid_rdValid", rdValid, 0);
      check("rstmid_fifoLevel", fifoLevel, 0);
      step();
      nRst = 1;
      @(negedge pixClk);
      check("rstrel_rdValid", rdValid, 0);
      check("rstrel_fifoLevel", fifoLevel, 0);
      check("rstrel_ovfl", ovfl, 0);
      step();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         wrPix  = 1'($urandom_range(0, 1));
         wrAddr = AW'($urandom);
         wrData = DW'($urandom);
         if (!(rdReq && !gnt_seen)) begin
            rdReq  = ($urandom_range(0, 3) != 0);
            rdAddr = AW'($urandom);
         end
         ovflClr = ($urandom_range(0, 15) == 0);
         step();
      end

      // drain
      wrPix = 0; rdReq = 0; ovflClr = 0;
      repeat (20) step();
      @(negedge pixClk);
      check("drain_wr_queue", exp_wr.size(), 0);
      check("drain_gnt_queue", exp_gnt.size(), 0);
      check("drain_rd_queue", exp_rd.size(), 0);
      check("drain_fifoLevel", fifoLevel, 0);
      check("max_write_wait_ok", max_run <= MAXB, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // global time limit
   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
